// File: rtl/neuron_mac_layer.sv
// Sequential fully-connected layer: streams IDIM inputs into ODIM signed MAC lanes,
// then rescales, saturates and presents one ODIM-wide result. Optional ReLU: NEURON_MAC_RELU_EN.
module neuron_mac_layer #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 8,
  parameter int IDIM   = 4,
  parameter int ODIM   = 2,
  parameter int ACCW   = 2*DWIDTH + $clog2(IDIM) + 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ODIM*DWIDTH-1:0]   bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DWIDTH-1:0]        in_x,
  input  logic [ODIM*DWIDTH-1:0]   in_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ODIM*DWIDTH-1:0]   out_y,
  output logic                     ovf,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_SCALE  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  localparam int CNTW = (IDIM > 1) ? $clog2(IDIM) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(IDIM - 1);

  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  // Returns {clamp_active, saturated lane value}; the shift floors toward -inf.
  function automatic logic [DWIDTH:0] sat_lane(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] t;
    t = a >>> FRAC;
    if (t > SAT_MAX)
      sat_lane = {1'b1, SAT_MAX[DWIDTH-1:0]};
    else if (t < SAT_MIN)
      sat_lane = {1'b1, SAT_MIN[DWIDTH-1:0]};
    else
      sat_lane = {1'b0, t[DWIDTH-1:0]};
  endfunction

`ifdef NEURON_MAC_RELU_EN
  function automatic logic [DWIDTH-1:0] relu(input logic [DWIDTH-1:0] v);
    relu = v[DWIDTH-1] ? '0 : v;
  endfunction
`endif

  logic [1:0]                   state;
  logic [CNTW-1:0]              cnt_p0;
  logic signed [ACCW-1:0]       acc_p0   [ODIM];
  logic signed [ACCW-1:0]       acc_next [ODIM];
  logic signed [ACCW-1:0]       bias_ext [ODIM];
  logic signed [2*DWIDTH-1:0]   prod     [ODIM];
  logic [DWIDTH:0]              sat_r    [ODIM];
  logic [ODIM-1:0]              lane_ovf;
  logic [ODIM*DWIDTH-1:0]       y_next;
  logic                         ovf_next;
  logic [ODIM*DWIDTH-1:0]       y_p1;
  logic                         vld_p1;

  // Stage p0: per-lane multiply-accumulate and bias preload
  always_comb begin
    for (int j = 0; j < ODIM; j++) begin
      prod[j]     = $signed(in_x) * $signed(in_w[j*DWIDTH +: DWIDTH]);
      acc_next[j] = acc_p0[j] + ACCW'(prod[j]);
      bias_ext[j] = ACCW'($signed(bias[j*DWIDTH +: DWIDTH])) <<< FRAC;
    end
  end

  // Stage p1: rescale, clamp and optional rectification of the final sums
  always_comb begin
    y_next   = '0;
    lane_ovf = '0;
    for (int j = 0; j < ODIM; j++) begin
      sat_r[j]    = sat_lane(acc_p0[j]);
      lane_ovf[j] = sat_r[j][DWIDTH];
`ifdef NEURON_MAC_RELU_EN
      y_next[j*DWIDTH +: DWIDTH] = relu(sat_r[j][DWIDTH-1:0]);
`else
      y_next[j*DWIDTH +: DWIDTH] = sat_r[j][DWIDTH-1:0];
`endif
    end
    ovf_next = |lane_ovf;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt_p0 <= '0;
      for (int j = 0; j < ODIM; j++) acc_p0[j] <= '0;
      y_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int j = 0; j < ODIM; j++) acc_p0[j] <= bias_ext[j];
            cnt_p0 <= '0;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            for (int j = 0; j < ODIM; j++) acc_p0[j] <= acc_next[j];
            cnt_p0 <= cnt_p0 + 1'b1;
            if (cnt_p0 == CNT_LAST) state <= S_SCALE;
          end
        end
        S_SCALE: begin
          y_p1   <= y_next;
          vld_p1 <= ovf_next;
          state  <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake flags are pure state decode, independent of in_valid/out_ready
  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_OUTPUT);
  assign busy      = (state != S_IDLE);
  assign out_y     = y_p1;
  assign ovf       = vld_p1;

endmodule

// File: tb/tb_neuron_mac_layer.sv
// Directed, table-driven bench for neuron_mac_layer (DWIDTH=16, FRAC=8, IDIM=4, ODIM=2).
module tb_neuron_mac_layer;

  localparam int DWIDTH = 16;
  localparam int FRAC   = 8;
  localparam int IDIM   = 4;
  localparam int ODIM   = 2;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   start = 1'b0;
  logic [ODIM*DWIDTH-1:0] bias = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DWIDTH-1:0]      in_x = '0;
  logic [ODIM*DWIDTH-1:0] in_w = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [ODIM*DWIDTH-1:0] out_y;
  logic                   ovf;
  logic                   busy;

  neuron_mac_layer #(.DWIDTH(DWIDTH), .FRAC(FRAC), .IDIM(IDIM), .ODIM(ODIM)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .ovf(ovf), .busy(busy)
  );

  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    string        name;
    logic [31:0]  b;
    logic [63:0]  xs;   // element e at [16*e +: 16]
    logic [127:0] ws;   // element e at [32*e +: 32] = {w1, w0}
    logic [31:0]  y;    // signed saturated result before any ReLU
    logic         ov;
  } vec_t;

  vec_t vecs[7];

  localparam logic [63:0]  X_BASIC = {4{16'h0100}};
  localparam logic [127:0] W_BASIC = {4{16'hFF00, 16'h0080}};

  function automatic logic [31:0] expect_y(input logic [31:0] y);
    logic [31:0] r;
    r = y;
`ifdef NEURON_MAC_RELU_EN
    for (int j = 0; j < ODIM; j++)
      if (r[j*DWIDTH + DWIDTH - 1]) r[j*DWIDTH +: DWIDTH] = '0;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic begin_txn(input logic [31:0] b);
    start = 1'b1;
    bias  = b;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [63:0] xs, input logic [127:0] ws, input int n,
                      input bit gap, input int start_at, input logic [31:0] alt_bias,
                      output int accepts);
    int  e;
    int  cyc;
    bit  acc;
    e = 0;
    cyc = 0;
    accepts = 0;
    while (e < n && cyc < 100) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_x     = xs[e*16 +: 16];
      in_w     = ws[e*32 +: 32];
      start    = (start_at >= 0) && (e == start_at);
      if (start) bias = alt_bias;
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc) begin
        e++;
        accepts++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic finish_txn(input string name, input logic [31:0] ey, input logic eov,
                            input int stall, input bit hs);
    int lat;
    lat = 0;
    chk({name, " ready_in_scale"}, 32'(in_ready), 32'd0);
    chk({name, " valid_in_scale"}, 32'(out_valid), 32'd0);
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd1);
    chk({name, " y"}, out_y, expect_y(ey));
    chk({name, " ovf"}, 32'(ovf), 32'(eov));
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      chk({name, " stall_valid"}, 32'(out_valid), 32'd1);
      chk({name, " stall_y"}, out_y, expect_y(ey));
    end
    if (hs) begin
      // START coincident with the handshake must not launch a new transaction
      out_ready = 1'b1;
      start     = 1'b1;
      bias      = 32'h7FFF_7FFF;
      @(posedge clock); #1;
      out_ready = 1'b0;
      start     = 1'b0;
      chk({name, " valid_drop"}, 32'(out_valid), 32'd0);
      chk({name, " busy_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int acc;

    vecs[0] = '{"basic",   32'h0000_0000, X_BASIC, W_BASIC, 32'hFC00_0200, 1'b0};
    vecs[1] = '{"sat",     32'h0000_0000, {4{16'h7FFF}}, {4{16'h8000, 16'h7FFF}}, 32'h8000_7FFF, 1'b1};
    vecs[2] = '{"biastr",  32'hFFFF_0180, 64'h0, {4{16'h0040, 16'h0100}}, 32'hFFFF_0180, 1'b0};
    vecs[3] = '{"floor",   32'h0000_0000, {16'h0000, 16'h0000, 16'h0000, 16'h0001},
                {4{16'hFFFF, 16'h0001}}, 32'hFFFF_0000, 1'b0};
    vecs[4] = '{"mixed",   32'hFF00_0100, {16'h0000, 16'h0080, 16'hFF00, 16'h0200},
                {4{16'h0040, 16'h0100}}, 32'hFF60_0280, 1'b0};
    vecs[5] = '{"edge",    32'h8000_7FFF, 64'h0, W_BASIC, 32'h8000_7FFF, 1'b0};
    vecs[6] = '{"edge+1",  32'h0000_7FFF, {16'h0000, 16'h0000, 16'h0000, 16'h0001},
                {4{16'h0000, 16'h0100}}, 32'h0000_7FFF, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_y", out_y, 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int v = 0; v < 7; v++) begin
      begin_txn(vecs[v].b);
      chk({vecs[v].name, " busy"}, 32'(busy), 32'd1);
      chk({vecs[v].name, " ready"}, 32'(in_ready), 32'd1);
      feed(vecs[v].xs, vecs[v].ws, IDIM, 1'b0, -1, 32'h0, acc);
      chk({vecs[v].name, " accepts"}, 32'(acc), 32'd4);
      finish_txn(vecs[v].name, vecs[v].y, vecs[v].ov, 0, 1'b1);
    end

    // Backpressure on both sides
    begin_txn(32'h0);
    feed(X_BASIC, W_BASIC, IDIM, 1'b1, -1, 32'h0, acc);
    chk("bp accepts", 32'(acc), 32'd4);
    finish_txn("bp", 32'hFC00_0200, 1'b0, 5, 1'b1);

    // START during ACCUM with a different bias is ignored
    begin_txn(32'h0);
    feed(X_BASIC, W_BASIC, IDIM, 1'b0, 1, 32'h0100_0100, acc);
    chk("sbusy accepts", 32'(acc), 32'd4);
    finish_txn("sbusy", 32'hFC00_0200, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("sbusy single_hs", 32'(out_valid), 32'd0);
    end

    // Reset after two accepts
    begin_txn(32'h0);
    feed(X_BASIC, W_BASIC, 2, 1'b0, -1, 32'h0, acc);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    begin_txn(32'h0);
    feed(X_BASIC, W_BASIC, IDIM, 1'b0, -1, 32'h0, acc);
    finish_txn("postrst", 32'hFC00_0200, 1'b0, 0, 1'b1);

    // Reset while a saturated result is being held
    begin_txn(32'h0);
    feed(vecs[1].xs, vecs[1].ws, IDIM, 1'b0, -1, 32'h0, acc);
    finish_txn("outrst", vecs[1].y, 1'b1, 2, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("outrst out_valid", 32'(out_valid), 32'd0);
    chk("outrst out_y", out_y, 32'd0);
    chk("outrst ovf", 32'(ovf), 32'd0);
    chk("outrst busy", 32'(busy), 32'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("outrst idle", 32'(in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/neuron_mac_layer.md
# neuron_mac_layer

Sequential fully-connected neuron layer that streams an IDIM-element input vector one element per cycle into ODIM parallel multiply-accumulate lanes. Each lane adds a per-lane bias, rescales from fixed-point product format, saturates, and optionally applies ReLU. The result is presented as one ODIM-wide output word under a valid/ready handshake. It succeeds the combinational outer-product neuron array and sits between the input feature stream and the next layer's input.

## Interface
- DWIDTH, 16: signed fixed-point data/weight/bias width
- FRAC, 8: fractional bits of data, weights, bias and output (Q format)
- IDIM, 4: input elements accumulated per transaction (≥1)
- ODIM, 2: output lanes (≥1)
- ACCW, 2*DWIDTH+$clog2(IDIM)+2: signed accumulator width
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous active-low reset
- START  in  1  begin transaction; honoured only when BUSY=0
- BIAS  in  ODIM*DWIDTH  per-lane bias, lane j at [DWIDTH*(j+1)-1 : DWIDTH*j], sampled on honoured START
- IN_VALID  in  1  IN_X/IN_W valid
- IN_READY  out  1  block accepts an element
- IN_X  in  DWIDTH  current input element
- IN_W  in  ODIM*DWIDTH  weight of current element for each lane (lane j slicing as BIAS)
- OUT_VALID  out  1  OUT_Y/OVF valid
- OUT_READY  in  1  consumer accepts result
- OUT_Y  out  ODIM*DWIDTH  lane results (lane j slicing as BIAS)
- OVF  out  1  any lane saturated in this result
- BUSY  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCUM, SCALE, OUTPUT.
- IDLE: IN_READY=0. On START: acc[j] ← sign-extend(BIAS[j]) <<< FRAC, cnt ← 0, → ACCUM.
- ACCUM: IN_READY=1. An accept (IN_VALID & IN_READY) does acc[j] ← acc[j] + signed(IN_X)*signed(IN_W[j]) and cnt ← cnt+1. An accept with cnt==IDIM-1 → SCALE. No accept: state holds.
- SCALE (one cycle): IN_READY=0. t[j] = acc[j] >>> FRAC (arithmetic, truncation toward −∞). Clamp t[j] to [−2^(DWIDTH−1), 2^(DWIDTH−1)−1] and register it into OUT_Y lane j. OVF ← OR over lanes of (clamp active) → OUTPUT.
- OUTPUT: OUT_VALID=1. OUT_Y and OVF stay stable until OUT_READY=1. On that cycle → IDLE, and OUT_VALID drops next cycle.
- START is ignored in every state except IDLE, including the OUTPUT cycle where OUT_READY handshakes.
- ACCW guarantees no accumulator overflow for any IDIM products plus bias. Saturation occurs only at the output clamp.
- Reset (any time, including mid-ACCUM or OUTPUT): state IDLE, cnt=0, acc=0. Outputs reset as below. The partial transaction is discarded.

## Timing
- Reset values: IN_READY=0, OUT_VALID=0, OUT_Y=0, OVF=0, BUSY=0.
- START sampled at edge k → BUSY=1 and IN_READY=1 from cycle k+1.
- Last accept at edge n → SCALE in cycle n+1 → OUT_VALID=1 from cycle n+2. Minimum transaction is IDIM+2 cycles from first IN_READY.
- IN_READY is registered state decode. It does not depend combinationally on IN_VALID.
- OUT_VALID never deasserts without OUT_READY, except on reset.
- Back-to-back: the earliest next START is the cycle after the OUTPUT handshake (IDLE).

## Configuration
- NEURON_MAC_RELU_EN defined: after clamp, negative lane values are replaced by 0. OVF still reflects clamp activity before ReLU.
- Undefined: signed saturated values are output unchanged.

## Test plan
All scenarios use DWIDTH=16, FRAC=8, IDIM=4, ODIM=2.
- Basic: BIAS=0, IN_X=0x0100 ×4, W0=0x0080, W1=0xFF00 → OUT_Y lane0=0x0200, lane1=0xFC00 (0x0000 with NEURON_MAC_RELU_EN), OVF=0, OUT_VALID exactly 2 cycles after the 4th accept.
- Backpressure: same data with IN_VALID toggling 1/0 and OUT_READY held low 5 cycles → identical result, OUT_Y/OUT_VALID stable throughout the stall, exactly 4 accepts counted.
- Saturation: IN_X=0x7FFF, W0=0x7FFF, W1=0x8000, BIAS=0 → lane0=0x7FFF; lane1=0x8000 (0x0000 with ReLU); OVF=1.
- Bias/truncation: BIAS0=0x0180, BIAS1=0xFFFF, IN_X=0 → lane0=0x0180, lane1=0xFFFF (ReLU: 0x0000), OVF=0.
- Reset mid-operation: assert RESET_N=0 after 2 accepts → IN_READY, OUT_VALID, OUT_Y, OVF, BUSY all 0 immediately. A subsequent basic transaction yields 0x0200/0xFC00 with no residue.
- START while BUSY: pulse START during ACCUM with a different BIAS → ignored, result matches the original bias, and only one OUT_VALID handshake occurs.
